// File: rtl/writeback_unit_pkg.sv
// Definitions shared between the execution unit and the writeback stage.
package writeback_unit_pkg;

  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_D = 2;

endpackage

// File: rtl/writeback_unit_reg_file.sv
// Architectural register file: one synchronous write port, two
// combinational read ports, r0 hardwired to zero.
module reg_file
  import writeback_unit_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] mem [NREGS];

  // Write port; writes aimed at r0 are dropped so it always stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: captures execution results, commits them to the register
// file one cycle later, keeps the flag register and the retire counter, and
// serves the operand read ports with forwarding from the pending write.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int         NREGS  = 8,
  parameter logic [3:0] OP_CMP = writeback_unit_pkg::OP_CMP,
  parameter logic [3:0] OP_NOP = writeback_unit_pkg::OP_NOP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_opcode,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic                 ex_zero,
  input  logic                 ex_carry,
  input  logic                 ex_div_done,
  input  logic                 stall,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]    rs1_data,
  output logic [DATA_W-1:0]    rs2_data,
  output logic [2:0]           flags,
  output logic                 wb_valid,
  output logic [15:0]          retired
);

  logic                 accept;
  logic                 is_nop;
  logic                 ex_we;
  logic                 commit;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [DATA_W-1:0]    wb_data;
  logic [DATA_W-1:0]    rf_rdata1;
  logic [DATA_W-1:0]    rf_rdata2;
  logic [2:0]           flags_in;

  assign accept = ex_valid && !stall;
  assign is_nop = (ex_opcode == OP_NOP);
  assign ex_we  = (ex_opcode != OP_CMP) && !is_nop && (ex_rd != '0);
  assign commit = wb_valid && wb_we && !stall;

  // Assemble the incoming flags using the shared bit positions.
  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_Z] = ex_zero;
    flags_in[FLAG_C] = ex_carry;
    flags_in[FLAG_D] = ex_div_done;
  end

  // Stage register: load on accept, drain when idle, freeze under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (!stall) begin
      wb_valid <= accept;
      if (accept) begin
        wb_we   <= ex_we;
        wb_rd   <= ex_rd;
        wb_data <= ex_result;
      end
    end
  end

  // Flag register and retire counter update on every accepted non-NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags   <= 3'b000;
      retired <= '0;
    end else if (accept && !is_nop) begin
      flags   <= flags_in;
      retired <= retired + 16'd1;
    end
  end

  reg_file #(.NREGS(NREGS)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Read ports: r0 is zero, then the pending write, then the register file.
  // No bypass from ex_result, which would close a loop through the ALU.
  always_comb begin
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wb_valid && wb_we && (wb_rd == rs1_addr))
      rs1_data = wb_data;
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wb_valid && wb_we && (wb_rd == rs2_addr))
      rs2_data = wb_data;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by a
// randomized stream, compared against an architectural model in which a
// register holds the newest accepted result written to it.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic [15:0] ex_result;
  logic        ex_zero;
  logic        ex_carry;
  logic        ex_div_done;
  logic        stall;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic [2:0]  flags;
  logic        wb_valid;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_regs [8];
  logic [2:0]  m_flags;
  logic [15:0] m_retired;
  logic        m_wbv;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_rd      (ex_rd),
    .ex_result  (ex_result),
    .ex_zero    (ex_zero),
    .ex_carry   (ex_carry),
    .ex_div_done(ex_div_done),
    .stall      (stall),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flags      (flags),
    .wb_valid   (wb_valid),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_flags   = 3'b000;
    m_retired = 16'h0000;
    m_wbv     = 1'b0;
  endtask

  // Apply one cycle of stimulus, clock it, and advance the model.
  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rd,
                      input logic [15:0] res, input logic z, input logic c,
                      input logic d, input logic stl);
    ex_valid = v; ex_opcode = op; ex_rd = rd; ex_result = res;
    ex_zero = z; ex_carry = c; ex_div_done = d; stall = stl;
    @(posedge clk);
    #1;
    if (v && !stl) begin
      m_wbv = 1'b1;
      if (op != 4'hF) begin
        m_flags   = {d, c, z};
        m_retired = m_retired + 16'd1;
      end
      if (op != 4'hE && op != 4'hF && rd != 3'd0) m_regs[rd] = res;
    end else if (!stl) begin
      m_wbv = 1'b0;
    end
    ex_valid = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".flags"},    {13'd0, flags},    {13'd0, m_flags});
    check({tag, ".retired"},  retired,           m_retired);
    check({tag, ".wb_valid"}, {15'd0, wb_valid}, {15'd0, m_wbv});
  endtask

  task automatic check_read(input string tag, input logic [2:0] a1, input logic [2:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    check({tag, ".rs1"}, rs1_data, m_regs[a1]);
    check({tag, ".rs2"}, rs2_data, m_regs[a2]);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) check_read(tag, 3'(i), 3'(7 - i));
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_opcode = 4'hF; ex_rd = 0; ex_result = 0;
    ex_zero = 0; ex_carry = 0; ex_div_done = 0; stall = 0;
    rs1_addr = 0; rs2_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Some activity, then an asynchronous reset in the middle of it.
    step(1, 4'h1, 3'd4, 16'hBEEF, 0, 1, 1, 0);
    step(1, 4'h0, 3'd6, 16'h0F0F, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_state("reset");
    check_all_regs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Simple write: forwarded next cycle, from the file after that.
    step(1, 4'h0, 3'd3, 16'h1234, 0, 1, 0, 0);
    check_state("wr3");
    check_read("wr3.fwd", 3'd3, 3'd0);
    step(0, 4'h0, 3'd0, 16'h0000, 0, 0, 0, 0);
    check_state("wr3.idle");
    check_read("wr3.file", 3'd3, 3'd3);

    // Back-to-back writes to the same register.
    step(1, 4'h1, 3'd5, 16'hAAAA, 0, 0, 0, 0);
    check_read("b2b.first", 3'd5, 3'd3);
    step(1, 4'h2, 3'd5, 16'h5555, 0, 0, 0, 0);
    check_read("b2b.second", 3'd5, 3'd5);
    step(0, 4'h0, 3'd0, 16'h0000, 0, 0, 0, 0);
    check_read("b2b.file", 3'd5, 3'd3);

    // CMP updates flags only; NOP touches nothing.
    step(1, 4'hE, 3'd3, 16'h0000, 1, 0, 0, 0);
    check_state("cmp");
    check_all_regs("cmp");
    step(1, 4'hF, 3'd3, 16'h9999, 0, 1, 1, 0);
    check_state("nop");
    check_all_regs("nop");

    // Write aimed at r0 is discarded.
    step(1, 4'h0, 3'd0, 16'hFFFF, 0, 0, 0, 0);
    check_read("r0", 3'd1, 3'd0);
    step(0, 4'h0, 3'd0, 16'h0000, 0, 0, 0, 0);
    check_read("r0.file", 3'd0, 3'd0);

    // Pending write to r2 held through three stall cycles.
    step(1, 4'h3, 3'd2, 16'h2222, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h0, 3'd2, 16'h7777, 1, 1, 0, 1);
      check_state("stall");
      check_read("stall.fwd", 3'd2, 3'd5);
    end
    step(0, 4'h0, 3'd0, 16'h0000, 0, 0, 0, 0);
    check_state("unstall");
    check_read("unstall.file", 3'd2, 3'd3);

    // Randomized stream.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 5))
        0:       op = 4'hE;
        1:       op = 4'hF;
        default: op = 4'($urandom_range(0, 13));
      endcase
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, op, 3'($urandom_range(0, 7)),
           16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      check_state("rand");
      check_read("rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (n == 200) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_state("rand.reset");
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    check_all_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
